// File: rtl/wb_csr_pkg.sv
// Shared constants for the Wishbone CSR bank of the PWM/timer array:
// register offsets inside a channel window, status bit positions and the
// number of read/write configuration registers per channel.
package wb_csr_pkg;

   // Read/write configuration registers held per channel
   localparam int unsigned REGS_PER_CH = 4;

   // Word offsets inside one channel's 8-word window
   localparam logic [2:0] CTRL    = 3'd0;
   localparam logic [2:0] PERIOD  = 3'd1;
   localparam logic [2:0] DIVISOR = 3'd2;
   localparam logic [2:0] DUTY    = 3'd3;
   localparam logic [2:0] STATUS  = 3'd4;

   // Sticky status bits
   localparam int unsigned ST_EVT = 0;
   localparam int unsigned ST_OVR = 1;

endpackage

// File: rtl/wb_csr_chan.sv
// One timer channel's register slice: four RW configuration registers with
// byte-lane writes, plus the sticky STATUS register (event / overrun) with
// write-1-to-clear. A new event wins over a clear arriving in the same cycle.
module wb_csr_chan
   import wb_csr_pkg::*;
#(
   parameter int unsigned DATA_W = 16
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [2:0]                    off,
   input  logic [DATA_W/8-1:0]           sel,
   input  logic [DATA_W-1:0]             wdata,
   input  logic                          evt,
   output logic [REGS_PER_CH*DATA_W-1:0] cfg,
   output logic [DATA_W-1:0]             rdata,
   output logic                          irq
);

   logic [REGS_PER_CH-1:0][DATA_W-1:0] regs;
   logic [DATA_W-1:0]                  lane_mask;
   logic                               st_evt;
   logic                               st_ovr;
   logic                               wr_status;
   logic                               clr_evt;
   logic                               clr_ovr;

   // Expand the byte-lane enables into a bit mask
   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < DATA_W/8; b++) begin
         lane_mask[8*b +: 8] = {8{sel[b]}};
      end
   end

   assign wr_status = wr_en & (off == STATUS);
   assign clr_evt   = wr_status & wdata[ST_EVT] & lane_mask[ST_EVT];
   assign clr_ovr   = wr_status & wdata[ST_OVR] & lane_mask[ST_OVR];

   // Configuration registers: merge enabled byte lanes on a write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else begin
         for (int k = 0; k < REGS_PER_CH; k++) begin
            if (wr_en && (off == 3'(k))) begin
               regs[k] <= (regs[k] & ~lane_mask) | (wdata & lane_mask);
            end
         end
      end
   end

   // Sticky status: set by event (overrun if already pending), W1C otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_evt <= 1'b0;
         st_ovr <= 1'b0;
      end else begin
         st_evt <= evt | (st_evt & ~clr_evt);
         st_ovr <= (evt & st_evt) | (st_ovr & ~clr_ovr);
      end
   end

   // Read port: select the register addressed by the word offset
   always_comb begin
      rdata = '0;
      case (off)
         CTRL:    rdata = regs[0];
         PERIOD:  rdata = regs[1];
         DIVISOR: rdata = regs[2];
         DUTY:    rdata = regs[3];
         STATUS: begin
            rdata[ST_EVT] = st_evt;
            rdata[ST_OVR] = st_ovr;
         end
         default: rdata = '0;
      endcase
   end

   assign cfg = regs;
   assign irq = st_evt;

endmodule

// File: rtl/wb_csr_bank.sv
// Wishbone classic slave holding the per-channel CSRs of the PWM/timer array.
// Address = {channel, offset[2:0]}; single-cycle registered ack, one transfer
// accepted every other cycle while the strobe is held.
// Optional feature macro: WB_CSR_ERR_EN -- invalid accesses answer with
// o_wb_err instead of o_wb_ack (default build: o_wb_err is constant 0).
module wb_csr_bank
   import wb_csr_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADR_W  = 16
)
(
   input  logic                                 i_wb_clk,
   input  logic                                 i_wb_rst,
   input  logic                                 i_wb_cyc,
   input  logic                                 i_wb_stb,
   input  logic                                 i_wb_we,
   input  logic [ADR_W-1:0]                     i_wb_adr,
   input  logic [DATA_W/8-1:0]                  i_wb_sel,
   input  logic [DATA_W-1:0]                    i_wb_data,
   input  logic [NUM_CH-1:0]                    i_evt,
   output logic                                 o_wb_ack,
   output logic                                 o_wb_err,
   output logic [DATA_W-1:0]                    o_wb_data,
   output logic [NUM_CH*REGS_PER_CH*DATA_W-1:0] o_cfg,
   output logic [NUM_CH-1:0]                    o_irq
);

   localparam int unsigned CH_W = ADR_W - 3;

   logic [CH_W-1:0]   chan_idx;
   logic [2:0]        off;
   logic              req;
   logic              addr_ok;
   logic              take_ack;
   logic              take_err;
   logic [NUM_CH-1:0] wr_en;
   logic [DATA_W-1:0] chan_rdata [NUM_CH];
   logic [DATA_W-1:0] rd_mux;

   assign chan_idx = i_wb_adr[ADR_W-1:3];
   assign off      = i_wb_adr[2:0];

   // A response in flight blocks re-acceptance of the same strobe
   assign req     = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err;
   assign addr_ok = ({1'b0, chan_idx} < (CH_W+1)'(NUM_CH)) && (off <= STATUS);

`ifdef WB_CSR_ERR_EN
   assign take_ack = req & addr_ok;
   assign take_err = req & ~addr_ok;
`else
   assign take_ack = req;
   assign take_err = 1'b0;
`endif

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
         assign wr_en[c] = req & i_wb_we & addr_ok & (chan_idx == CH_W'(c));

         wb_csr_chan #(
            .DATA_W (DATA_W)
         ) u_chan (
            .clk   (i_wb_clk),
            .rst   (i_wb_rst),
            .wr_en (wr_en[c]),
            .off   (off),
            .sel   (i_wb_sel),
            .wdata (i_wb_data),
            .evt   (i_evt[c]),
            .cfg   (o_cfg[c*REGS_PER_CH*DATA_W +: REGS_PER_CH*DATA_W]),
            .rdata (chan_rdata[c]),
            .irq   (o_irq[c])
         );
      end
   endgenerate

   // Read mux: only the addressed, valid channel contributes
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rd_mux = rd_mux | ((addr_ok && (chan_idx == CH_W'(c))) ? chan_rdata[c] : '0);
      end
   end

   // Response flags: one cycle after the accepting edge
   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         o_wb_ack <= 1'b0;
         o_wb_err <= 1'b0;
      end else begin
         o_wb_ack <= take_ack;
         o_wb_err <= take_err;
      end
   end

   // Read data register: updated only by acknowledged reads, holds otherwise
   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         o_wb_data <= '0;
      end else if (take_ack && !i_wb_we) begin
         o_wb_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Directed, table-driven bench for wb_csr_bank (NUM_CH=4, DATA_W=16).
module tb_wb_csr_bank;

`ifdef WB_CSR_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         cyc;
   logic         stb;
   logic         we;
   logic [15:0]  adr;
   logic [1:0]   sel;
   logic [15:0]  wdat;
   logic [3:0]   evt;
   logic         ack;
   logic         err;
   logic [15:0]  rdat;
   logic [255:0] cfg;
   logic [3:0]   irq;

   int checks   = 0;
   int failures = 0;

   logic         got_ack;
   logic         got_err;
   logic [15:0]  got_data;
   logic [15:0]  model_last;
   logic [255:0] exp_cfg;
   logic [5:0]   ack_pat;

   typedef struct {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [15:0] adr;
      logic [1:0]  sel;
      logic [15:0] wdata;
      logic        inv;
      logic [15:0] rd;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   wb_csr_bank #(.NUM_CH(4), .DATA_W(16), .ADR_W(16)) dut (
      .i_wb_clk  (clk),
      .i_wb_rst  (rst),
      .i_wb_cyc  (cyc),
      .i_wb_stb  (stb),
      .i_wb_we   (we),
      .i_wb_adr  (adr),
      .i_wb_sel  (sel),
      .i_wb_data (wdat),
      .i_evt     (evt),
      .o_wb_ack  (ack),
      .o_wb_err  (err),
      .o_wb_data (rdat),
      .o_cfg     (cfg),
      .o_irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   task automatic set_vec(input int i, input logic c, input logic s, input logic w,
                          input logic [15:0] a, input logic [1:0] sl, input logic [15:0] d,
                          input logic inv, input logic [15:0] rd);
      vecs[i].cyc = c;  vecs[i].stb = s;    vecs[i].we  = w;
      vecs[i].adr = a;  vecs[i].sel = sl;   vecs[i].wdata = d;
      vecs[i].inv = inv; vecs[i].rd = rd;
   endtask

   // One transfer starting just after a rising edge; samples the response
   // cycle, then leaves one idle cycle.
   task automatic drive_req(input logic c, input logic s, input logic w,
                            input logic [15:0] a, input logic [1:0] sl, input logic [15:0] d);
      cyc = c; stb = s; we = w; adr = a; sel = sl; wdat = d;
      @(posedge clk); #1;
      got_ack = ack; got_err = err; got_data = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_evt(input logic [3:0] m);
      evt = m;
      @(posedge clk); #1;
      evt = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = 16'h0000; sel = 2'b00; wdat = 16'h0000; evt = 4'b0000;
      model_last = 16'h0000;

      //          cyc   stb   we    adr       sel    wdata     inv   rd
      set_vec( 0, 1'b1, 1'b1, 1'b0, 16'h0001, 2'b00, 16'h0000, 1'b0, 16'h0000);
      set_vec( 1, 1'b1, 1'b1, 1'b1, 16'h0013, 2'b01, 16'hBEEF, 1'b0, 16'h0000);
      set_vec( 2, 1'b1, 1'b1, 1'b1, 16'h0013, 2'b10, 16'h12FF, 1'b0, 16'h0000);
      set_vec( 3, 1'b1, 1'b1, 1'b0, 16'h0013, 2'b00, 16'h0000, 1'b0, 16'h12EF);
      set_vec( 4, 1'b1, 1'b1, 1'b1, 16'h0008, 2'b11, 16'hA5C3, 1'b0, 16'h0000);
      set_vec( 5, 1'b1, 1'b1, 1'b0, 16'h0008, 2'b00, 16'h0000, 1'b0, 16'hA5C3);
      set_vec( 6, 1'b1, 1'b1, 1'b1, 16'h001A, 2'b00, 16'hFFFF, 1'b0, 16'h0000);
      set_vec( 7, 1'b1, 1'b1, 1'b0, 16'h001A, 2'b00, 16'h0000, 1'b0, 16'h0000);
      set_vec( 8, 1'b1, 1'b1, 1'b1, 16'h0000, 2'b11, 16'h5A5A, 1'b0, 16'h0000);
      set_vec( 9, 1'b1, 1'b1, 1'b1, 16'h0020, 2'b11, 16'h1234, 1'b1, 16'h0000);
      set_vec(10, 1'b1, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 1'b1, 16'h0000);
      set_vec(11, 1'b1, 1'b1, 1'b0, 16'h0006, 2'b00, 16'h0000, 1'b1, 16'h0000);
      set_vec(12, 1'b1, 1'b1, 1'b1, 16'h000D, 2'b11, 16'hFFFF, 1'b1, 16'h0000);
      set_vec(13, 1'b1, 1'b1, 1'b0, 16'h000D, 2'b00, 16'h0000, 1'b1, 16'h0000);
      set_vec(14, 1'b1, 1'b0, 1'b1, 16'h0000, 2'b11, 16'hDEAD, 1'b0, 16'h0000);
      set_vec(15, 1'b0, 1'b1, 1'b1, 16'h0000, 2'b11, 16'hDEAD, 1'b0, 16'h0000);
      set_vec(16, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h5A5A);
      set_vec(17, 1'b1, 1'b1, 1'b1, 16'h0019, 2'b11, 16'h0F0F, 1'b0, 16'h0000);
      set_vec(18, 1'b1, 1'b1, 1'b0, 16'h0019, 2'b00, 16'h0000, 1'b0, 16'h0F0F);
      set_vec(19, 1'b1, 1'b1, 1'b1, 16'h0004, 2'b11, 16'hFFFF, 1'b0, 16'h0000);
      set_vec(20, 1'b1, 1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000, 1'b0, 16'h0000);
      set_vec(21, 1'b1, 1'b1, 1'b0, 16'h0009, 2'b00, 16'h0000, 1'b0, 16'h0000);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",  256'(ack),  256'(1'b0));
      check("rst_err",  256'(err),  256'(1'b0));
      check("rst_data", 256'(rdat), 256'(16'h0000));
      check("rst_cfg",  cfg,        256'(0));
      check("rst_irq",  256'(irq),  256'(4'b0000));
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven transfers
      for (int i = 0; i < NV; i++) begin
         logic resp;
         logic e_ack;
         logic e_err;
         resp  = vecs[i].cyc & vecs[i].stb;
         e_ack = resp & ~(vecs[i].inv & ERR_EN);
         e_err = resp & vecs[i].inv & ERR_EN;
         drive_req(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdata);
         if (e_ack && !vecs[i].we) begin
            model_last = vecs[i].inv ? 16'h0000 : vecs[i].rd;
         end
         check($sformatf("v%0d_ack", i),  256'(got_ack),  256'(e_ack));
         check($sformatf("v%0d_err", i),  256'(got_err),  256'(e_err));
         check($sformatf("v%0d_data", i), 256'(got_data), 256'(model_last));
      end

      exp_cfg = '0;
      exp_cfg[0*16   +: 16] = 16'h5A5A;
      exp_cfg[4*16   +: 16] = 16'hA5C3;
      exp_cfg[11*16  +: 16] = 16'h12EF;
      exp_cfg[13*16  +: 16] = 16'h0F0F;
      check("cfg_after_table", cfg, exp_cfg);

      // Two events on channel 1: pending + overrun, then W1C of bit 0
      pulse_evt(4'b0010);
      pulse_evt(4'b0010);
      drive_req(1'b1, 1'b1, 1'b0, 16'h000C, 2'b00, 16'h0000);
      check("evt1_status", 256'(got_data), 256'(16'h0003));
      check("evt1_irq",    256'(irq[1]),   256'(1'b1));
      drive_req(1'b1, 1'b1, 1'b1, 16'h000C, 2'b11, 16'h0001);
      check("w1c_ack", 256'(got_ack), 256'(1'b1));
      drive_req(1'b1, 1'b1, 1'b0, 16'h000C, 2'b00, 16'h0000);
      check("w1c_status", 256'(got_data), 256'(16'h0002));
      check("w1c_irq",    256'(irq[1]),   256'(1'b0));

      // Event on channel 0 in the same cycle as its W1C: set wins
      pulse_evt(4'b0001);
      check("evt0_irq", 256'(irq[0]), 256'(1'b1));
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0004; sel = 2'b11; wdat = 16'h0001;
      evt = 4'b0001;
      @(posedge clk); #1;
      evt = 4'b0000;
      check("race_ack", 256'(ack), 256'(1'b1));
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      drive_req(1'b1, 1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000);
      check("race_status", 256'(got_data), 256'(16'h0003));
      check("race_irq",    256'(irq[0]),   256'(1'b1));

      // Strobe held for 6 cycles: responses on alternating cycles
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h001B; sel = 2'b11; wdat = 16'h00AA;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         ack_pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("stream_pattern", 256'(ack_pat), 256'(6'b010101));
      check("stream_count",   256'($countones(ack_pat)), 256'(3));
      exp_cfg[15*16 +: 16] = 16'h00AA;
      check("stream_cfg", cfg, exp_cfg);

      // Reset during a response: ack drops at once, everything cleared
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0000; sel = 2'b11; wdat = 16'hFFFF;
      @(posedge clk); #1;
      check("pre_rst_ack", 256'(ack), 256'(1'b1));
      rst = 1'b1;
      #1;
      check("mid_rst_ack",  256'(ack),  256'(1'b0));
      check("mid_rst_cfg",  cfg,        256'(0));
      check("mid_rst_irq",  256'(irq),  256'(4'b0000));
      check("mid_rst_data", 256'(rdat), 256'(16'h0000));
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      drive_req(1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000);
      check("post_rst_ack",  256'(got_ack),  256'(1'b1));
      check("post_rst_ctrl", 256'(got_data), 256'(16'h0000));
      check("post_rst_cfg",  cfg,            256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
